filter_mem_responder: RTL and testbench
=======================================

Name: filter_mem_responder

Overview:
- Data-memory responder and host front end for the filter GPU pipeline.
- Owns the pixel RAM and answers the GPU's 3-lane data port: A1/A2/A3 addresses, ReadData, writeData, MemWriteM.
- Host side streams an image in, releases the GPU, detects halt or timeout, then streams the result out.
- Sits between the host/DMA link and the filter GPU core.

Parameters:
- DW, 18, pixel word width (one lane).
- AW, 10, lane address width.
- DEPTH, 1024, RAM words; must be <= 2**AW.
- LANES, 3, lanes per access (fixed 3).
- HALT_PC, 32'h0000_00FC, GPU PC value meaning "program finished".
- MAX_CYCLES, 32'd1_000_000, RUN timeout in cycles.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- host_valid  in  1  load word valid.
- host_data  in  DW  load word.
- host_ready  out  1  load word accepted when valid&ready.
- out_valid  out  1  dump word valid.
- out_data  out  DW  dump word.
- out_ready  in  1  host accepts dump word.
- gpu_rst  out  1  reset to GPU core; high except in RUN.
- PC  in  32  GPU program counter.
- A1, A2, A3  in  AW  GPU lane addresses.
- MemWriteM  in  1  GPU write strobe (all 3 lanes).
- writeData  in  3xDW  packed lane write data.
- ReadData  out  3xDW  packed lane read data.
- done  out  1  result fully dumped.
- timeout  out  1  RUN ended by MAX_CYCLES, not halt.
- cycle_count  out  32  RUN cycles of the last/current run.

Behaviour:
- Reset values: state IDLE, gpu_rst=1, host_ready=0, out_valid=0, out_data=0, done=0, timeout=0, cycle_count=0, ReadData=0, pointers=0. RAM contents are not reset.
- Reset mid-operation: returns to IDLE immediately; the partial load/dump is discarded.
- IDLE:
  - start -> LOAD; ptr=0; timeout=0.
- LOAD:
  - host_ready=1.
  - On host_valid&host_ready: mem[ptr]<=host_data; ptr++.
  - The word at ptr==DEPTH-1 is the last; on it go -> RUN, ptr=0, cycle_count=0.
  - host_valid without ready is never lost: ready is constant in LOAD.
- RUN:
  - gpu_rst=0 while in RUN.
  - ReadData[i] = mem[Ai] combinationally, zero-latency, as the GPU memory stage expects. Addr >= DEPTH reads 0.
  - MemWriteM=1: all 3 lanes written at the clock edge. Addr >= DEPTH writes are dropped.
  - Equal addresses on multiple lanes: the highest lane index wins (lane 3 over 2 over 1).
  - Read-during-write to the same address returns old data; the write is visible next cycle.
  - cycle_count++ each RUN cycle, saturating at 2^32-1.
  - PC==HALT_PC -> DUMP; gpu_rst=1 from the next cycle. A GPU write in that same cycle is still committed.
  - cycle_count==MAX_CYCLES-1 without halt -> DUMP with timeout<=1.
  - Halt and timeout in the same cycle: halt wins, timeout=0.
- DUMP:
  - ReadData=0; out_valid=1; out_data=mem[ptr].
  - On out_ready: ptr++.
  - The handshake at ptr==DEPTH-1 is the last -> DONE.
  - out_data holds stable while out_valid&!out_ready.
- DONE:
  - done=1, gpu_rst=1; cycle_count and timeout are held.
  - start -> LOAD and clears done.
- start outside IDLE/DONE is ignored.
- Write data is truncated to DW; no arithmetic on data.

Decomposition:
- Package filter_mem_pkg:
  - state_t enum: IDLE, LOAD, RUN, DUMP, DONE.
  - DW, AW, LANES constants.
  - pixel_t typedef: logic [DW-1:0].
  - lane_vec_t typedef: logic [2:0][DW-1:0].
- One sub-module tri_port_ram:
  - 3 async read ports, 3-lane single-strobe write, lane-priority resolve, out-of-range guard.
  - Also serves the host write/read through lane 1 muxing.
- The FSM, counters and handshake stay in filter_mem_responder.

Test Plan:
- Reset, then load ramp mem[i]=i with host_valid held high -> host_ready high for exactly 1024 cycles, then gpu_rst drops. Drive PC=HALT_PC at once -> dump yields 0..1023 in order, then done=1, cycle_count=1.
- RUN, A1=5,A2=6,A3=7, MemWriteM=1, writeData={3,2,1}; next cycle read back -> ReadData={3,2,1}. Same-cycle read of A1=5 returns the old value 5.
- RUN, A1=A2=A3=10, writeData={0x3FFFF,0x2,0x1}, write -> mem[10]=0x3FFFF (lane 3 wins).
- Never assert halt, MAX_CYCLES=100 -> DUMP entered after 100 RUN cycles, timeout=1, cycle_count=100.
- In DUMP, toggle out_ready 1,0,0,1 -> out_data stable during stalls, exactly 1024 handshakes, no skipped or duplicated word.
- Assert RST during LOAD at ptr=300 -> next cycle IDLE, gpu_rst=1, host_ready=0. A new start reloads from ptr=0.

Source files
------------

// File: rtl/filter_mem_pkg.sv
// ============================================================================
// Module   : filter_mem_pkg
// Brief    : Shared types and widths for the filter GPU memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package filter_mem_pkg;

    localparam int DW    = 18;
    localparam int AW    = 10;
    localparam int LANES = 3;

    typedef logic [DW-1:0]             pixel_t;
    typedef logic [LANES-1:0][DW-1:0]  lane_vec_t;
    typedef logic [LANES-1:0][AW-1:0]  lane_addr_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DUMP = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tri_port_ram.sv
// ============================================================================
// Module   : tri_port_ram
// Brief    : Pixel RAM with three async read lanes and a three-lane write
//            where the highest lane index wins on address collisions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_port_ram
    import filter_mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic [LANES-1:0] i_we,
    input  lane_addr_t       i_addr,
    input  lane_vec_t        i_wdata,
    output lane_vec_t        o_rdata
);

    localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pixel_t                       r_mem [DEPTH];
    logic [LANES-1:0]             w_inrange;
    logic [LANES-1:0][c_IW-1:0]   w_idx;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // A RAM that fills the whole address space needs no range guard.
            if (DEPTH < (1 << AW)) begin : g_guard
                assign w_inrange[gi] = (32'(i_addr[gi]) < DEPTH);
            end else begin : g_full
                assign w_inrange[gi] = 1'b1;
            end
            assign w_idx[gi]   = i_addr[gi][c_IW-1:0];
            assign o_rdata[gi] = w_inrange[gi] ? r_mem[w_idx[gi]] : '0;
        end
    endgenerate

    // Later non-blocking writes override earlier ones: lane 3 beats 2 beats 1.
    always_ff @(posedge clk) begin
        if (i_we[0] && w_inrange[0]) r_mem[w_idx[0]] <= i_wdata[0];
        if (i_we[1] && w_inrange[1]) r_mem[w_idx[1]] <= i_wdata[1];
        if (i_we[2] && w_inrange[2]) r_mem[w_idx[2]] <= i_wdata[2];
    end

endmodule

`default_nettype wire

// File: rtl/filter_mem_responder.sv
// ============================================================================
// Module   : filter_mem_responder
// Brief    : Host load/dump front end and zero-latency 3-lane data memory
//            for the filter GPU core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_mem_responder
    import filter_mem_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] HALT_PC    = 32'h0000_00FC,
    parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                host_valid,
    input  logic [DW-1:0]       host_data,
    output logic                host_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready,
    output logic                gpu_rst,
    input  logic [31:0]         PC,
    input  logic [AW-1:0]       A1,
    input  logic [AW-1:0]       A2,
    input  logic [AW-1:0]       A3,
    input  logic                MemWriteM,
    input  logic [LANES*DW-1:0] writeData,
    output logic [LANES*DW-1:0] ReadData,
    output logic                done,
    output logic                timeout,
    output logic [31:0]         cycle_count
);

    localparam logic [AW-1:0] c_LAST     = AW'(DEPTH - 1);
    localparam logic [31:0]   c_TMO_LAST = MAX_CYCLES - 32'd1;

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_ptr, w_ptr_nxt;
    logic [31:0]      r_cycle_count, w_cycle_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic [LANES-1:0] w_we;
    lane_addr_t       w_addr;
    lane_vec_t        w_wdata;
    lane_vec_t        w_rdata;

    tri_port_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (CLK),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cycle_count <= w_cycle_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cycle_nxt   = r_cycle_count;
        w_timeout_nxt = r_timeout;

        // Outside RUN the host owns lane 1; the other lanes stay idle.
        w_we       = '0;
        w_addr     = {r_ptr, r_ptr, r_ptr};
        w_wdata    = {host_data, host_data, host_data};

        host_ready = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        ReadData   = '0;
        gpu_rst    = 1'b1;
        done       = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                done = (r_state == DONE);
                if (start) begin
                    w_state_nxt   = LOAD;
                    w_ptr_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            LOAD: begin
                host_ready = 1'b1;
                w_we[0]    = host_valid;
                if (host_valid) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                    if (r_ptr == c_LAST) begin
                        w_state_nxt = RUN;
                        w_ptr_nxt   = '0;
                        w_cycle_nxt = '0;
                    end
                end
            end
            RUN: begin
                gpu_rst  = 1'b0;
                w_addr   = {A3, A2, A1};
                w_wdata  = writeData;
                w_we     = {LANES{MemWriteM}};
                ReadData = w_rdata;
                w_cycle_nxt = (r_cycle_count == '1) ? r_cycle_count
                                                     : r_cycle_count + 32'd1;
                // Halt takes precedence over a coincident timeout.
                if (PC == HALT_PC) begin
                    w_state_nxt   = DUMP;
                    w_ptr_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end else if (r_cycle_count == c_TMO_LAST) begin
                    w_state_nxt   = DUMP;
                    w_ptr_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end
            end
            DUMP: begin
                out_valid = 1'b1;
                out_data  = w_rdata[0];
                if (out_ready) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                    if (r_ptr == c_LAST) begin
                        w_state_nxt = DONE;
                        w_ptr_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_filter_mem_responder.sv
// ============================================================================
// Module   : tb_filter_mem_responder
// Brief    : Directed self-checking bench for filter_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_mem_responder;
    import filter_mem_pkg::*;

    localparam logic [31:0] HALT = 32'h0000_00FC;

    logic                CLK = 1'b0;
    logic                RST;
    logic                start;
    logic                host_valid;
    logic [DW-1:0]       host_data;
    logic                host_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic                out_ready;
    logic                gpu_rst;
    logic [31:0]         PC;
    logic [AW-1:0]       A1, A2, A3;
    logic                MemWriteM;
    logic [LANES*DW-1:0] writeData;
    logic [LANES*DW-1:0] ReadData;
    logic                done;
    logic                timeout;
    logic [31:0]         cycle_count;

    int     errors = 0;
    int     checks = 0;
    pixel_t model [1024];

    filter_mem_responder #(
        .DEPTH      (1024),
        .HALT_PC    (HALT),
        .MAX_CYCLES (32'd100)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .gpu_rst     (gpu_rst),
        .PC          (PC),
        .A1          (A1),
        .A2          (A2),
        .A3          (A3),
        .MemWriteM   (MemWriteM),
        .writeData   (writeData),
        .ReadData    (ReadData),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic pixel_t pat(input int kind, input int i);
        return (kind == 0) ? DW'(i) : DW'(1023 - i);
    endfunction

    task automatic load_image(input int kind, input int stop_at, output int n);
        n = 0;
        host_valid = 1'b1;
        while (host_ready && n < stop_at) begin
            host_data = pat(kind, n);
            model[n]  = pat(kind, n);
            step();
            n++;
        end
        host_valid = 1'b0;
    endtask

    // out_ready follows 1,0,0,1 so every word sees stalls around it.
    task automatic dump_image(input string tag);
        logic [3:0] rdy_pat;
        int hs;
        int cyc;
        rdy_pat = 4'b1001;
        hs  = 0;
        cyc = 0;
        while (out_valid && hs < 1024 && cyc < 6000) begin
            out_ready = rdy_pat[cyc % 4];
            check({tag, "_data"}, out_data, model[hs]);
            step();
            if (out_ready) hs++;
            cyc++;
        end
        out_ready = 1'b0;
        check({tag, "_handshakes"}, hs, 1024);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_valid_low"}, out_valid, 1'b0);
    endtask

    initial begin
        int n;
        int k;
        RST        = 1'b1;
        start      = 1'b0;
        host_valid = 1'b0;
        host_data  = '0;
        out_ready  = 1'b0;
        PC         = HALT;
        A1         = 10'd5;
        A2         = 10'd6;
        A3         = 10'd1023;
        MemWriteM  = 1'b0;
        writeData  = '0;

        repeat (3) step();
        check("rst_gpu_rst",     gpu_rst,     1'b1);
        check("rst_host_ready",  host_ready,  1'b0);
        check("rst_out_valid",   out_valid,   1'b0);
        check("rst_out_data",    out_data,    '0);
        check("rst_done",        done,        1'b0);
        check("rst_timeout",     timeout,     1'b0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_readdata",    ReadData,    '0);
        RST = 1'b0;
        step();

        // Run 1: ramp load, immediate halt, full dump.
        pulse_start();
        check("load1_ready", host_ready, 1'b1);
        load_image(0, 2000, n);
        check("load1_count",      n,          1024);
        check("run1_gpu_rst",     gpu_rst,    1'b0);
        check("run1_ready_low",   host_ready, 1'b0);
        check("run1_readdata",    ReadData,   {18'd1023, 18'd6, 18'd5});
        step();
        check("dump1_valid",       out_valid,   1'b1);
        check("dump1_gpu_rst",     gpu_rst,     1'b1);
        check("dump1_readdata",    ReadData,    '0);
        check("dump1_cycle_count", cycle_count, 32'd1);
        check("dump1_timeout",     timeout,     1'b0);
        dump_image("dump1");

        // Run 2: GPU writes, read-during-write, lane priority, halt-cycle write.
        PC = 32'd0;
        pulse_start();
        check("load2_done_clear", done,       1'b0);
        check("load2_ready",      host_ready, 1'b1);
        load_image(0, 2000, n);
        check("load2_count", n, 1024);
        A1 = 10'd5; A2 = 10'd6; A3 = 10'd7;
        writeData = {18'd3, 18'd2, 18'd1};
        MemWriteM = 1'b1;
        #1;
        check("rdw_old_data", ReadData, {18'd7, 18'd6, 18'd5});
        step();
        MemWriteM = 1'b0;
        #1;
        check("write_readback", ReadData, {18'd3, 18'd2, 18'd1});
        model[5] = 18'd1; model[6] = 18'd2; model[7] = 18'd3;
        A1 = 10'd10; A2 = 10'd10; A3 = 10'd10;
        writeData = {18'h3FFFF, 18'd2, 18'd1};
        MemWriteM = 1'b1;
        step();
        MemWriteM = 1'b0;
        #1;
        check("lane3_wins", ReadData, {18'h3FFFF, 18'h3FFFF, 18'h3FFFF});
        model[10] = 18'h3FFFF;
        A1 = 10'd20; A2 = 10'd21; A3 = 10'd22;
        writeData = {18'h30000, 18'h20000, 18'h10000};
        MemWriteM = 1'b1;
        PC = HALT;
        step();
        MemWriteM = 1'b0;
        PC = 32'd0;
        model[20] = 18'h10000; model[21] = 18'h20000; model[22] = 18'h30000;
        check("dump2_valid",       out_valid,   1'b1);
        check("dump2_cycle_count", cycle_count, 32'd3);
        check("dump2_readdata",    ReadData,    '0);
        dump_image("dump2");

        // Run 3: no halt, timeout after MAX_CYCLES.
        pulse_start();
        load_image(0, 2000, n);
        check("load3_count", n, 1024);
        k = 0;
        while (gpu_rst === 1'b0 && k < 1000) begin
            step();
            k++;
        end
        check("tmo_run_cycles",  k,           100);
        check("tmo_flag",        timeout,     1'b1);
        check("tmo_cycle_count", cycle_count, 32'd100);
        check("tmo_dump_valid",  out_valid,   1'b1);
        pulse_start();
        check("start_ignored_valid", out_valid,  1'b1);
        check("start_ignored_ready", host_ready, 1'b0);
        check("stalled_word0",       out_data,   model[0]);

        // Asynchronous reset mid-dump takes effect without a clock edge.
        #2;
        RST = 1'b1;
        #1;
        check("arst_out_valid",   out_valid,   1'b0);
        check("arst_gpu_rst",     gpu_rst,     1'b1);
        check("arst_timeout",     timeout,     1'b0);
        check("arst_cycle_count", cycle_count, 32'd0);
        step();
        RST = 1'b0;

        // Reset during a partial load, then reload from the start.
        pulse_start();
        load_image(1, 300, n);
        check("partial_count", n,          300);
        check("partial_ready", host_ready, 1'b1);
        RST = 1'b1;
        step();
        check("lrst_host_ready", host_ready, 1'b0);
        check("lrst_gpu_rst",    gpu_rst,    1'b1);
        check("lrst_out_valid",  out_valid,  1'b0);
        RST = 1'b0;
        step();

        // Run 4: halt arrives on the same cycle as the timeout.
        pulse_start();
        load_image(1, 2000, n);
        check("load4_count", n, 1024);
        repeat (99) step();
        check("run4_still_running", gpu_rst, 1'b0);
        PC = HALT;
        step();
        PC = 32'd0;
        check("halt_wins_valid",   out_valid,   1'b1);
        check("halt_wins_timeout", timeout,     1'b0);
        check("halt_wins_count",   cycle_count, 32'd100);
        dump_image("dump4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
